// File: rtl/apb_master_arbiter.sv
// Round-robin arbiter sharing one APB master port among NB_REQ requesters.
// Optional ACCESS-phase timeout is compiled in when APB_ARB_TIMEOUT_EN is defined.
module apb_master_arbiter #(
  parameter int unsigned NB_REQ         = 4,
  parameter int unsigned APB_ADDR_WIDTH = 32,
  parameter int unsigned APB_DATA_WIDTH = 32,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic                               clk_i,
  input  logic                               rst_ni,
  input  logic [NB_REQ-1:0]                  req_i,
  input  logic [NB_REQ-1:0]                  we_i,
  input  logic [NB_REQ*APB_ADDR_WIDTH-1:0]   addr_i,
  input  logic [NB_REQ*APB_DATA_WIDTH-1:0]   wdata_i,
  output logic [NB_REQ-1:0]                  gnt_o,
  output logic [NB_REQ-1:0]                  rsp_valid_o,
  output logic [APB_DATA_WIDTH-1:0]          rsp_rdata_o,
  output logic                               rsp_err_o,
  output logic                               psel_o,
  output logic                               penable_o,
  output logic                               pwrite_o,
  output logic [APB_ADDR_WIDTH-1:0]          paddr_o,
  output logic [APB_DATA_WIDTH-1:0]          pwdata_o,
  input  logic [APB_DATA_WIDTH-1:0]          prdata_i,
  input  logic                               pready_i,
  input  logic                               pslverr_i
);

  localparam int unsigned IDX_W = (NB_REQ > 1) ? $clog2(NB_REQ) : 1;

  if (NB_REQ < 2 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("apb_master_arbiter: NB_REQ must be >= 2 and TIMEOUT_CYCLES >= 1");
  end

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_e;

  state_e                    state_q, state_d;
  logic [IDX_W-1:0]          last_grant_q, last_grant_d;
  logic                      pwrite_q, pwrite_d;
  logic [APB_ADDR_WIDTH-1:0] paddr_q, paddr_d;
  logic [APB_DATA_WIDTH-1:0] pwdata_q, pwdata_d;
  logic [NB_REQ-1:0]         rsp_valid_q, rsp_valid_d;
  logic [APB_DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                      rsp_err_q, rsp_err_d;
  logic [NB_REQ-1:0]         gnt;
  logic                      req_found;
  logic [IDX_W-1:0]          winner;

  logic [APB_ADDR_WIDTH-1:0] addr_arr  [NB_REQ];
  logic [APB_DATA_WIDTH-1:0] wdata_arr [NB_REQ];

  for (genvar g = 0; g < NB_REQ; g++) begin : g_unpack
    assign addr_arr[g]  = addr_i[g*APB_ADDR_WIDTH +: APB_ADDR_WIDTH];
    assign wdata_arr[g] = wdata_i[g*APB_DATA_WIDTH +: APB_DATA_WIDTH];
  end

`ifdef APB_ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;
`endif

  // Search begins just past the previous winner, so the last winner has lowest priority.
  always_comb begin : p_arb
    int unsigned cand;
    cand      = 0;
    req_found = 1'b0;
    winner    = '0;
    for (int unsigned i = 1; i <= NB_REQ; i++) begin
      cand = (32'(last_grant_q) + i) % NB_REQ;
      if (!req_found && req_i[IDX_W'(cand)]) begin
        req_found = 1'b1;
        winner    = IDX_W'(cand);
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    pwrite_d     = pwrite_q;
    paddr_d      = paddr_q;
    pwdata_d     = pwdata_q;
    rsp_valid_d  = '0;
    rsp_rdata_d  = rsp_rdata_q;
    rsp_err_d    = rsp_err_q;
    gnt          = '0;
`ifdef APB_ARB_TIMEOUT_EN
    tmo_cnt_d    = tmo_cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (req_found) begin
          gnt[winner]  = 1'b1;
          pwrite_d     = we_i[winner];
          paddr_d      = addr_arr[winner];
          pwdata_d     = wdata_arr[winner];
          last_grant_d = winner;
          state_d      = SETUP;
        end
      end
      SETUP: begin
        state_d = ACCESS;
`ifdef APB_ARB_TIMEOUT_EN
        tmo_cnt_d = '0;
`endif
      end
      ACCESS: begin
        // last_grant_q still names the owner of the transfer in flight.
        if (pready_i) begin
          rsp_valid_d[last_grant_q] = 1'b1;
          rsp_rdata_d = pwrite_q ? '0 : prdata_i;
          rsp_err_d   = pslverr_i;
          state_d     = IDLE;
        end
`ifdef APB_ARB_TIMEOUT_EN
        else if (tmo_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          rsp_valid_d[last_grant_q] = 1'b1;
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b1;
          state_d     = IDLE;
        end else begin
          tmo_cnt_d = tmo_cnt_q + CNT_W'(1);
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      last_grant_q <= IDX_W'(NB_REQ - 1);
      pwrite_q     <= 1'b0;
      paddr_q      <= '0;
      pwdata_q     <= '0;
      rsp_valid_q  <= '0;
      rsp_rdata_q  <= '0;
      rsp_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      pwrite_q     <= pwrite_d;
      paddr_q      <= paddr_d;
      pwdata_q     <= pwdata_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_rdata_q  <= rsp_rdata_d;
      rsp_err_q    <= rsp_err_d;
    end
  end

`ifdef APB_ARB_TIMEOUT_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) tmo_cnt_q <= '0;
    else         tmo_cnt_q <= tmo_cnt_d;
  end
`endif

  // Grant is combinational, so it is masked to keep it low while reset is held.
  assign gnt_o       = gnt & {NB_REQ{rst_ni}};
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_rdata_o = rsp_rdata_q;
  assign rsp_err_o   = rsp_err_q;
  assign psel_o      = (state_q != IDLE);
  assign penable_o   = (state_q == ACCESS);
  assign pwrite_o    = pwrite_q;
  assign paddr_o     = paddr_q;
  assign pwdata_o    = pwdata_q;

endmodule
